// File: rtl/fu_pkg.sv
// Shared opcodes, FSM state encoding and the op-to-unit decode for the FU dispatcher.
package fu_pkg;

    localparam logic [3:0] OP_ALU0    = 4'd0;
    localparam logic [3:0] OP_ALU7    = 4'd7;
    localparam logic [3:0] OP_FADD    = 4'd8;
    localparam logic [3:0] OP_FSUB    = 4'd9;
    localparam logic [3:0] OP_FMUL    = 4'd10;
    localparam logic [3:0] OP_FDIV    = 4'd11;
    localparam logic [3:0] OP_F2I     = 4'd12;
    localparam logic [3:0] OP_I2FU    = 4'd13;
    localparam logic [3:0] OP_I2FS    = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    localparam int TIMEOUT_DEF = 63;

    // Bit positions in the one-hot unit select vector.
    localparam int U_ALU  = 0;
    localparam int U_FAS  = 1;
    localparam int U_FMUL = 2;
    localparam int U_FDIV = 3;
    localparam int U_F2I  = 4;
    localparam int U_I2F  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Illegal opcode selects no unit at all.
    function automatic logic [5:0] unit_sel(input logic [3:0] op);
        logic [5:0] s;
        s = 6'b0;
        case (op)
            OP_FADD, OP_FSUB: s[U_FAS]  = 1'b1;
            OP_FMUL:          s[U_FMUL] = 1'b1;
            OP_FDIV:          s[U_FDIV] = 1'b1;
            OP_F2I:           s[U_F2I]  = 1'b1;
            OP_I2FU, OP_I2FS: s[U_I2F]  = 1'b1;
            OP_ILLEGAL:       s = 6'b0;
            default:          s[U_ALU]  = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fu_dispatch_if.sv
// Request/result handshake bundle between the dispatcher and its issuer/consumer.
interface fu_dispatch_if;
    import fu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_x1;
    logic [31:0] req_x2;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_err;

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, res_ready,
        output req_ready, res_valid, res_data, res_err
    );

    modport master (
        output req_valid, req_op, req_x1, req_x2, res_ready,
        input  req_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/fu_dispatch.sv
// Issue/collect sequencer: one op at a time to one execution unit, result held until consumed.
// Latency: ALU add 3, f2i 3, illegal 1, otherwise unit cycles + 2; watchdog turns a hung unit into an error.
module fu_dispatch
    import fu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    fu_dispatch_if.slave bus,
    input  logic        flush,
    output logic [31:0] fu_x1,
    output logic [31:0] fu_x2,
    output logic        fu_hold,
    output logic        alu_en,
    output logic [2:0]  alu_mode,
    output logic        fas_en,
    output logic        fas_mode,
    output logic        fmul_en,
    output logic        fdiv_en,
    output logic        i2f_en,
    output logic        i2f_mode,
    input  logic [63:0] alu_y,
    input  logic        alu_cplt,
    input  logic [31:0] fas_y,
    input  logic        fas_cplt,
    input  logic [31:0] fmul_y,
    input  logic        fmul_cplt,
    input  logic [31:0] fdiv_y,
    input  logic        fdiv_cplt,
    input  logic [31:0] i2f_y,
    input  logic        i2f_cplt,
    input  logic [31:0] f2i_y
);

    localparam logic [5:0] TMO = 6'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] x1_q, x1_d, x2_q, x2_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;

    logic [5:0]  sel;
    logic [63:0] sel_y;
    logic        sel_cplt;
    logic        cplt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 4'd0;
            x1_q       <= 32'd0;
            x2_q       <= 32'd0;
            cnt_q      <= 6'd0;
            res_data_q <= 64'd0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // f2i is combinational, so it "completes" on the first cycle stale completions are honoured.
    always_comb begin
        sel      = unit_sel(op_q);
        sel_y    = 64'd0;
        sel_cplt = 1'b0;
        if (sel[U_ALU])  begin sel_y = alu_y;            sel_cplt = alu_cplt;  end
        if (sel[U_FAS])  begin sel_y = {32'd0, fas_y};   sel_cplt = fas_cplt;  end
        if (sel[U_FMUL]) begin sel_y = {32'd0, fmul_y};  sel_cplt = fmul_cplt; end
        if (sel[U_FDIV]) begin sel_y = {32'd0, fdiv_y};  sel_cplt = fdiv_cplt; end
        if (sel[U_F2I])  begin sel_y = {32'd0, f2i_y};   sel_cplt = (cnt_q == 6'd1); end
        if (sel[U_I2F])  begin sel_y = {32'd0, i2f_y};   sel_cplt = i2f_cplt;  end
        cplt_hit = sel_cplt && (cnt_q != 6'd0);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d  = bus.req_op;
                    x1_d  = bus.req_x1;
                    x2_d  = bus.req_x2;
                    cnt_d = 6'd0;
                    if (bus.req_op == OP_ILLEGAL) begin
                        state_d    = ST_DONE;
                        res_data_d = 64'd0;
                        res_err_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cplt_hit) begin
                    state_d    = ST_DONE;
                    res_data_d = sel_y;
                    res_err_d  = 1'b0;
                end else if (cnt_q == TMO) begin
                    state_d    = ST_DONE;
                    res_data_d = 64'd0;
                    res_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Enables exist only in ISSUE, so every unit sees a low enable between ops.
    always_comb begin
        logic [5:0] en;
        en       = (state_q == ST_ISSUE) ? sel : 6'b0;
        alu_en   = en[U_ALU];
        fas_en   = en[U_FAS];
        fmul_en  = en[U_FMUL];
        fdiv_en  = en[U_FDIV];
        i2f_en   = en[U_I2F];
        alu_mode = op_q[2:0];
        fas_mode = (op_q == OP_FSUB);
        i2f_mode = (op_q == OP_I2FS);
        fu_hold  = (state_q == ST_ISSUE);
        fu_x1    = x1_q;
        fu_x2    = x2_q;
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;

endmodule

// File: doc/fu_dispatch.md
# fu_dispatch

Issue/collect sequencer that sits directly upstream of the execution units: the integer ALU, float add/sub, float mul, float div, float→int and int→float. It accepts one operation per valid/ready handshake and registers the operands. It drives exactly one unit's enable and mode until that unit reports completion, then captures the result into a 64-bit output register. The result is held under valid/ready backpressure, and a watchdog turns a hung unit into an error completion.

## Interface
- TIMEOUT, 63: maximum ISSUE cycles before forced error completion (≤63, 6-bit counter).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  opcode: 0–7 integer ALU mode (same encoding as ALU mode); 8 fadd; 9 fsub; 10 fmul; 11 fdiv; 12 f2i; 13 i2f unsigned; 14 i2f signed; 15 illegal.
- req_x1, req_x2  in  32  operands.
- flush  in  1  abandon the in-flight op.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  64  result; 32-bit results are zero-extended.
- res_err  out  1  illegal opcode or timeout.
- fu_x1, fu_x2  out  32  registered operands to all units.
- fu_hold  out  1  drives the units' cpu_isStop; high in ISSUE.
- alu_en / alu_mode  out  1 / 3
- fas_en / fas_mode  out  1 / 1
- fmul_en, fdiv_en  out  1
- i2f_en / i2f_mode  out  1 / 1
- alu_y  in  64;  alu_cplt  in  1
- fas_y, fmul_y, fdiv_y, i2f_y  in  32;  matching *_cplt  in  1
- f2i_y  in  32  combinational converter output.

## Operation
- States: IDLE, ISSUE, DONE. 2-bit encoding, shared enum.
- IDLE: req_valid && req_ready latches op, x1 and x2.
  - Ops 0–14 go to ISSUE.
  - Op 15 goes directly to DONE with res_data=0 and res_err=1.
- ISSUE:
  - Exactly one *_en is high, selected by the latched op. All other enables are 0.
  - Modes: fas_mode=1 for op 9; i2f_mode=1 for op 14; alu_mode=op[2:0].
  - 6-bit cnt clears on entry and increments each ISSUE cycle.
- Stale-completion rule: the selected *_cplt is ignored while cnt==0 (first ISSUE cycle). A unit's cplt left set by a previous zero-operand shortcut must not complete the new op.
- Completion (cnt≥1 and selected cplt=1):
  - Capture the selected y into res_data.
  - res_err=0; go to DONE.
  - Op 12 needs no cplt: f2i_y is captured at cnt==1.
- Timeout: cnt==TIMEOUT with no completion → DONE with res_data=0 and res_err=1.
- Flush in ISSUE → IDLE with no result. Flush in IDLE or DONE is ignored.
- DONE:
  - res_valid=1; all enables 0, so the units reset.
  - res_valid && res_ready → IDLE.
  - res_data and res_err stay stable while res_ready=0.
- Enable guarantee: every enable is low for at least one cycle between consecutive ops (DONE or IDLE always precedes ISSUE), so the units return to their idle index.
- Reset values:
  - state=IDLE, so req_ready=1 from the first cycle after reset.
  - All enables 0, fu_hold 0, res_valid 0, res_data 0, res_err 0, fu_x1 0, fu_x2 0, cnt 0.
- rst during ISSUE drops the enable on the next cycle. The op is discarded and no result is produced.

## Timing
- Accept at edge T. ISSUE spans cycles T+1 onward; the enable is visible from T+1.
- A completion sampled at edge E gives res_valid=1 in cycle E+1.
- Latency from accept to res_valid:
  - unit cycles + 2 (ALU add/sub: 3, i.e. cplt is sampled at cnt==1);
  - f2i: 3;
  - illegal opcode: 1.
- Throughput: one op per (latency + 1) cycles when res_ready is tied high.

## Structure
- Package fu_pkg holds:
  - opcode localparams OP_ALU0..OP_ILLEGAL;
  - the state enum;
  - the TIMEOUT default;
  - op-to-unit decode function unit_sel(op) returning a one-hot 6-bit vector.
- No sub-module. The unit instances live in the parent; this block holds only the FSM, operand/result registers and the mux.

## Test plan
- Op 0 (unsigned add), x1=5, x2=7, alu_cplt=1 combinationally → res_data=12, res_err=0, res_valid 3 cycles after accept.
- Op 10 (fmul), 0x40000000 × 0x40400000 with the real FPU_Mul attached → res_data=0x40C00000; fmul_en high continuously until capture, then low.
- Op 11 (fdiv), 0x40C00000 / 0x40000000 → 0x40400000.
- Stale completion:
  - fmul x1=0 (shortcut), then fmul 0x3F800000 × 0x40000000;
  - the second op must return 0x40000000, not 0;
  - no capture at cnt==0.
- Backpressure: hold res_ready=0 for 10 cycles → res_valid, res_data and res_err stable, req_ready=0, all enables 0; release → IDLE on the next edge.
- Error paths:
  - op 15 → res_err=1, res_data=0 after 1 cycle;
  - fmul_cplt tied 0 → res_err=1 after 63 ISSUE cycles;
  - rst or flush mid-ISSUE → enable low next cycle, no res_valid, req_ready=1.
